// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the on-board I/O block.
//   PRESCALE_DISPLAY_N  : prescaler width for the ~500 Hz display-mux clock
//   PRESCALE_DEBOUNCE_N : prescaler width for the ~50 Hz debounce sample clock
//   PRESCALER_N_MIN/MAX : legal range of the prescaler width parameter
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int PRESCALE_DISPLAY_N  = 16;
  localparam int PRESCALE_DEBOUNCE_N = 20;
  localparam int PRESCALER_N_MIN     = 1;
  localparam int PRESCALER_N_MAX     = 32;

endpackage : io_pkg

// File: rtl/prescaler.sv
// -----------------------------------------------------------------------------
// prescaler
// Free-running binary clock divider: clk_out = MSB of an N-bit up-counter,
// giving clk/2^N at 50 % duty.
//
// Parameters:
//   N        counter width, 1..32 (default io_pkg::PRESCALE_DISPLAY_N)
// Ports:
//   clk      input   system clock, rising-edge active
//   rst_n    input   asynchronous active-low reset
//   clk_out  output  divided clock, driven straight from counter bit N-1
//   tick     output  one-cycle strobe in the cycle count is 0 after a wrap
//                    (exists only when PRESCALER_TICK_EN is defined)
//
// Build option: define PRESCALER_TICK_EN to add the tick port and its flop.
// -----------------------------------------------------------------------------
module prescaler
  import io_pkg::*;
#(
  parameter int N = PRESCALE_DISPLAY_N
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
`ifdef PRESCALER_TICK_EN
  ,
  output logic tick
`endif
);

  // Out-of-range widths stop elaboration rather than building a broken divider.
  if (N < PRESCALER_N_MIN || N > PRESCALER_N_MAX) begin : g_bad_n
    $error("prescaler: N=%0d outside %0d..%0d", N, PRESCALER_N_MIN, PRESCALER_N_MAX);
  end

  logic [N-1:0] count_q, count_d;

  // Wraps naturally modulo 2^N; no saturation or stall.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    count_d = count_q + N'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the async reset clears outputs immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Taken directly from a flop output so the derived clock cannot glitch.
  assign clk_out = count_q[N-1];

`ifdef PRESCALER_TICK_EN
  logic tick_q, tick_d;

  // Registering "count is all-ones" puts the strobe in the cycle where count
  // has just wrapped to 0, aligned with the falling edge of clk_out.
  always_comb begin
    tick_d = (count_q == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule : prescaler

// File: tb/tb_prescaler.sv
// -----------------------------------------------------------------------------
// tb_prescaler
// Directed testbench for prescaler at N=4, N=1 and N=16. Expected values are
// derived from edge numbers counted since reset release.
// -----------------------------------------------------------------------------
module tb_prescaler;

  logic clk;
  logic rst_n;
  logic rst16_n;
  logic clk_out4, clk_out1, clk_out16;
`ifdef PRESCALER_TICK_EN
  logic tick4, tick1, tick16;
`endif

  int errors = 0;
  int checks = 0;

  prescaler #(.N(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_out4)
`ifdef PRESCALER_TICK_EN
    ,
    .tick    (tick4)
`endif
  );

  prescaler #(.N(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_out1)
`ifdef PRESCALER_TICK_EN
    ,
    .tick    (tick1)
`endif
  );

  prescaler #(.N(16)) u_dut16 (
    .clk     (clk),
    .rst_n   (rst16_n),
    .clk_out (clk_out16)
`ifdef PRESCALER_TICK_EN
    ,
    .tick    (tick16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected N=4 clk_out after edge e since release: high for counts 8..15.
  function automatic logic exp4(input int e);
    return ((e % 16) >= 8);
  endfunction

  task automatic check_n4_edge(input string tag, input int e);
    check({tag, " clk_out4"}, {31'd0, clk_out4}, {31'd0, exp4(e)});
    check({tag, " clk_out1"}, {31'd0, clk_out1}, {31'd0, logic'(e % 2)});
`ifdef PRESCALER_TICK_EN
    check({tag, " tick4"}, {31'd0, tick4}, {31'd0, logic'(e > 0 && (e % 16) == 0)});
`endif
  endtask

  task automatic main_seq();
    int rises;
    logic prev;
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset clk_out4", {31'd0, clk_out4}, 32'd0);
      check("reset clk_out1", {31'd0, clk_out1}, 32'd0);
`ifdef PRESCALER_TICK_EN
      check("reset tick4", {31'd0, tick4}, 32'd0);
`endif
    end
    rst_n = 1'b1;

    // Four full periods; also count rising edges of clk_out4.
    rises = 0;
    prev  = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      @(negedge clk);
      check_n4_edge("run", e);
      if (clk_out4 && !prev) rises++;
      prev = clk_out4;
    end
    check("rise count", rises, 32'd4);

    // Advance to edge 75 (count=11, clk_out4 high), then reset mid-period.
    for (int e = 65; e <= 75; e++) @(negedge clk);
    check("pre-reset clk_out4", {31'd0, clk_out4}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async clear clk_out4", {31'd0, clk_out4}, 32'd0);
`ifdef PRESCALER_TICK_EN
    check("async clear tick4", {31'd0, tick4}, 32'd0);
`endif
    repeat (2) begin
      @(negedge clk);
      check("held reset clk_out4", {31'd0, clk_out4}, 32'd0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      check_n4_edge("rerun", e);
    end
  endtask

  task automatic n16_seq();
    rst16_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset clk_out16", {31'd0, clk_out16}, 32'd0);
    rst16_n = 1'b1;
    for (int e = 1; e <= 65536; e++) begin
      @(negedge clk);
      if (e == 32767) check("n16 edge 32767", {31'd0, clk_out16}, 32'd0);
      if (e == 32768) check("n16 edge 32768", {31'd0, clk_out16}, 32'd1);
      if (e == 65535) check("n16 edge 65535", {31'd0, clk_out16}, 32'd1);
      if (e == 65536) check("n16 edge 65536", {31'd0, clk_out16}, 32'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rst16_n = 1'b0;
    fork
      main_seq();
      n16_seq();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prescaler
